// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared state encoding, bus widths and byte-lane mapping for the memory responder
package cpu_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int WORD_BYTES = 4;
  localparam int BE_W = WORD_BYTES;
  function automatic int lane_lsb(input int i);
    return 24 - 8 * i;
  endfunction
endpackage

// File: rtl/cpu_mem_ram.sv
// cpu_mem_ram: single-port synchronous RAM with big-endian byte-lane write mask and registered read
module cpu_mem_ram
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [BE_W-1:0]   be,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++)
        if (we && be[BE_W-1-i]) mem[addr][lane_lsb(i) +: 8] <= wdata[lane_lsb(i) +: 8];
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: one-at-a-time memory responder with configurable wait states and error checking
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_rdata,
  output logic            resp_err,
  output logic            busy
);
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 0..15");
  end
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic we_r, err, access;
  logic [31:0] addr_r, wdata_r, ram_q;
  logic [BE_W-1:0] be_r;
  assign err = (|addr_r[1:0]) || (|addr_r[31:ADDR_W+2]);
  assign access = state == WAIT && cnt == 4'd0 && !err && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
    if (state == IDLE && req_valid) {we_r, addr_r, wdata_r, be_r} <= {req_we, req_addr, req_wdata, req_be};
  end
  always_comb begin
    state_n    = state == IDLE ? (req_valid ? WAIT : IDLE) :
                 state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) :
                 (resp_ready ? IDLE : RESP);
    cnt_n      = state == IDLE && req_valid ? 4'(WAIT_CYCLES) :
                 state == WAIT && cnt != 4'd0 ? cnt - 4'd1 : cnt;
    req_ready  = state == IDLE;
    busy       = state != IDLE;
    resp_valid = state == RESP;
    resp_err   = resp_valid && err;
    resp_rdata = resp_valid && !err && !we_r ? ram_q : '0;
  end
  cpu_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (access),
    .we    (we_r),
    .addr  (addr_r[ADDR_W+1:2]),
    .wdata (wdata_r),
    .be    (be_r),
    .rdata (ram_q)
  );
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed vector table plus multi-cycle sequences for cpu_mem_responder
module tb_cpu_mem_responder;
  logic clk = 0, rst = 1, we = 0;
  logic [1:0] req_valid = '0, resp_ready = '1;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] be = '0;
  logic rq0, rv0, er0, bz0, rq1, rv1, er1, bz1;
  logic [31:0] rd0, rd1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  cpu_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(rq0), .req_we(we), .req_addr(addr),
    .req_wdata(wdata), .req_be(be), .resp_valid(rv0), .resp_ready(resp_ready[0]), .resp_rdata(rd0),
    .resp_err(er0), .busy(bz0));
  cpu_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(rq1), .req_we(we), .req_addr(addr),
    .req_wdata(wdata), .req_be(be), .resp_valid(rv1), .resp_ready(resp_ready[1]), .resp_rdata(rd1),
    .resp_err(er1), .busy(bz1));
  typedef struct {
    logic w;
    logic [31:0] a, d;
    logic [3:0] b;
    logic [31:0] exp_rd;
    logic exp_err;
  } vec_t;
  vec_t v[20];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic issue(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic rr);
    @(negedge clk);
    we = w; addr = a; wdata = d; be = b;
    resp_ready[s] = rr;
    req_valid[s] = 1'b1;
    @(posedge clk);
    #1 req_valid[s] = 1'b0;
  endtask
  task automatic wait_resp(input int s, output int n);
    n = 0;
    while (!(s == 1 ? rv1 : rv0) && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
  endtask
  task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output logic er, output int n);
    issue(s, w, a, d, b, 1'b1);
    wait_resp(s, n);
    rd = s == 1 ? rd1 : rd0;
    er = s == 1 ? er1 : er0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd;
    logic er;
    int n;
    v[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    v[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    v[2]  = '{1'b1, 32'h10,   32'h11223344, 4'h5, 32'h0,        1'b0};
    v[3]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDE22BE44, 1'b0};
    v[4]  = '{1'b0, 32'h13,   32'h0,        4'hF, 32'h0,        1'b1};
    v[5]  = '{1'b1, 32'h0,    32'h12345678, 4'hF, 32'h0,        1'b0};
    v[6]  = '{1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    v[7]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h12345678, 1'b0};
    v[8]  = '{1'b1, 32'h0,    32'hAABBCCDD, 4'h0, 32'h0,        1'b0};
    v[9]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h12345678, 1'b0};
    v[10] = '{1'b1, 32'h3FC,  32'h01020304, 4'hF, 32'h0,        1'b0};
    v[11] = '{1'b1, 32'h3FC,  32'hAAAAAAAA, 4'h8, 32'h0,        1'b0};
    v[12] = '{1'b0, 32'h3FC,  32'h0,        4'h0, 32'hAA020304, 1'b0};
    v[13] = '{1'b0, 32'h1002, 32'h0,        4'h0, 32'h0,        1'b1};
    v[14] = '{1'b1, 32'h20,   32'h01010101, 4'hF, 32'h0,        1'b0};
    v[15] = '{1'b1, 32'h28,   32'h28282828, 4'hF, 32'h0,        1'b0};
    v[16] = '{1'b1, 32'h40,   32'h55667788, 4'hF, 32'h0,        1'b0};
    v[17] = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h01010101, 1'b0};
    v[18] = '{1'b1, 32'h2,    32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    v[19] = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h12345678, 1'b0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset req_ready", 32'(rq0), 32'd1);
    chk("reset resp_valid", 32'(rv0), 32'd0);
    chk("reset busy", 32'(bz0), 32'd0);
    chk("reset resp_rdata", rd0, 32'h0);
    chk("reset resp_err", 32'(er0), 32'd0);
    for (int i = 0; i < 20; i++) begin
      txn(0, v[i].w, v[i].a, v[i].d, v[i].b, rd, er, n);
      chk($sformatf("v%0d latency", i), 32'(n), 32'd3);
      chk($sformatf("v%0d rdata", i), rd, v[i].exp_rd);
      chk($sformatf("v%0d err", i), 32'(er), 32'(v[i].exp_err));
    end
    issue(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    wait_resp(0, n);
    chk("bp latency", 32'(n), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      we = 1'b1; addr = 32'h40; wdata = 32'h0; be = 4'hF;
      req_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d resp_valid", k), 32'(rv0), 32'd1);
      chk($sformatf("bp%0d rdata", k), rd0, 32'h55667788);
      chk($sformatf("bp%0d req_ready", k), 32'(rq0), 32'd0);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release resp_valid", 32'(rv0), 32'd0);
    chk("bp release req_ready", 32'(rq0), 32'd1);
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, n);
    chk("bp ignored req", rd, 32'h55667788);
    foreach (v[j]) if (j < 3) begin
      int d;
      d = j == 0 ? 0 : j == 1 ? 2 : 3;
      issue(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0);
      repeat (d) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("rst d%0d busy", d), 32'(bz0), 32'd0);
      chk($sformatf("rst d%0d resp_valid", d), 32'(rv0), 32'd0);
      chk($sformatf("rst d%0d req_ready", d), 32'(rq0), 32'd1);
      rst = 1'b0;
      resp_ready[0] = 1'b1;
      txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, n);
      chk($sformatf("rst d%0d readback", d), rd, d == 3 ? 32'hCAFEF00D : 32'h01010101);
    end
    @(negedge clk);
    rst = 1'b1;
    we = 1'b1; addr = 32'h28; wdata = 32'h0; be = 4'hF;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    rst = 1'b0;
    chk("rst+req busy", 32'(bz0), 32'd0);
    @(posedge clk);
    #1 chk("rst+req still idle", 32'(bz0), 32'd0);
    txn(0, 1'b0, 32'h28, 32'h0, 4'h0, rd, er, n);
    chk("rst+req readback", rd, 32'h28282828);
    txn(1, 1'b1, 32'h20, 32'h13579BDF, 4'hF, rd, er, n);
    chk("w0 write latency", 32'(n), 32'd1);
    chk("w0 write err", 32'(er), 32'd0);
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, n);
    chk("w0 read latency", 32'(n), 32'd1);
    chk("w0 read rdata", rd, 32'h13579BDF);
    issue(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("w0 rst busy", 32'(bz1), 32'd0);
    chk("w0 rst resp_valid", 32'(rv1), 32'd0);
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, n);
    chk("w0 rst readback", rd, 32'h13579BDF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU's load/store and fetch bus. It is the other end of the CPU's memory requests.
- Accepts one request at a time over a valid/ready handshake and performs a word read or a byte-masked write into internal RAM.
- Returns data with a configurable number of wait states, so the CPU's stall logic can be exercised in simulation.
- Instantiated next to the CPU in the top-level testbench.

Parameters:
- ADDR_W, 10, word-address width; the RAM holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, extra wait states between accept and access; legal range 0..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables; lane 0 = most significant byte (big-endian).
- resp_valid  out  1  response present.
- resp_ready  in  1  CPU accepts the response.
- resp_rdata  out  32  read data; 0 for writes and errors.
- resp_err  out  1  misaligned or out-of-range access.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; busy=0; wait counter 0.
  - RAM contents are not cleared by rst.
- States:
  - IDLE: req_ready=1. On req_valid, latch we/addr/wdata/be, load counter=WAIT_CYCLES, go to WAIT.
  - WAIT: if counter==0, perform the access this cycle and go to RESP; otherwise decrement the counter.
  - RESP: resp_valid=1; rdata and err are held stable until resp_ready. On resp_ready, go to IDLE.
- Latency: request accepted in cycle 0 -> resp_valid first high in cycle WAIT_CYCLES+2.
  - No back-to-back accept: req_ready returns one cycle after the response handshake.
- Access legality:
  - addr[1:0] must be 00.
  - addr[31:ADDR_W+2] must be 0.
  - Otherwise resp_err=1, rdata=0, and no RAM write occurs.
- Read: returns the full word at word index addr[ADDR_W+1:2]; req_be is ignored.
- Write:
  - Only lanes with be=1 are updated; the other lanes are preserved.
  - be=0000 is a legal no-op write with err=0.
  - The write is committed on the clock edge leaving WAIT.
- Read-after-write to the same word on consecutive transactions returns the new data.
- req_valid while not in IDLE is ignored. Request inputs need not be held after acceptance.
- Reset mid-operation:
  - Any state returns to IDLE on the next edge; resp_valid drops.
  - A write not yet committed (still in WAIT) is discarded. An already-committed write persists.
- Simultaneous rst and req_valid: reset wins; the request is not accepted.
- Counter width is 4 bits; WAIT_CYCLES > 15 is a configuration error, flagged by an elaboration-time check.

Decomposition:
- Shared package cpu_mem_pkg:
  - state encoding (IDLE, WAIT, RESP)
  - constants WORD_BYTES=4 and BE_W=4
  - the lane-to-bit mapping: lane i covers bits 31-8i .. 24-8i
- One sub-module, cpu_mem_ram: single-port synchronous RAM, 2^ADDR_W x 32, with a byte-write mask and a registered read.
- The responder FSM, legality check and response registers live in cpu_mem_responder.

Test Plan:
- Reset/idle: rst for 2 cycles -> req_ready=1, resp_valid=0, busy=0, resp_rdata=0.
- Write then read, WAIT_CYCLES=2:
  - write addr 0x10, data 0xDEADBEEF, be=1111 -> resp_valid in cycle 4, err=0.
  - read 0x10 -> rdata=0xDEADBEEF.
- Byte mask: word 0x10 = 0xDEADBEEF; write data 0x11223344, be=0101 -> read 0x10 returns 0xDE22BE44.
- Errors:
  - read 0x13 -> err=1, rdata=0.
  - write to 0x1000 with ADDR_W=10 -> err=1.
  - then read 0x0 -> unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and rdata stable, req_ready=0, a second req_valid is ignored; release -> IDLE the next cycle.
- Reset mid-op:
  - assert rst during WAIT of a write to 0x20 (data 0xCAFEF00D) -> IDLE next cycle; a later read of 0x20 returns the old value.
  - repeat with WAIT_CYCLES=0 -> response in cycle 2.
